// File: rtl/o8_bus_arbiter.sv
// Two-master round-robin arbiter for the o8 memory bus (m0 = CPU, m1 = DMA/loader).
// Optional ack/err watchdog in the granted state: define O8_ARB_TIMEOUT_EN.
module o8_bus_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    input  logic              m0_rd_i,
    input  logic              m0_wr_i,
    output logic [DATA_W-1:0] m0_data_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    input  logic              m1_rd_i,
    input  logic              m1_wr_i,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic [DATA_W-1:0] s_data_o,
    input  logic [DATA_W-1:0] s_data_i,
    output logic              s_rd_o,
    output logic              s_wr_o,
    input  logic              s_ack_i,
    input  logic              s_err_i,
    output logic [1:0]        gnt_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t             r_state, w_next;
    logic               r_last, w_last_nxt;   // 1: m1 was served last
    logic               w_sel;
    logic               w_rd, w_wr, w_req, w_viol, w_rsp, w_tmo;
    logic               w_ack, w_err;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_data;

    always_comb begin
        w_sel  = (r_state == GNT1);
        w_rd   = w_sel ? m1_rd_i   : m0_rd_i;
        w_wr   = w_sel ? m1_wr_i   : m0_wr_i;
        w_addr = w_sel ? m1_addr_i : m0_addr_i;
        w_data = w_sel ? m1_data_i : m0_data_i;
    end

    assign w_req  = w_rd | w_wr;
    assign w_viol = w_rd & w_wr;
    assign w_rsp  = s_ack_i | s_err_i;

`ifdef O8_ARB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    // Counts silent granted cycles; IDLE always precedes a grant, so clearing there covers entry.
    always_ff @(posedge clk_i) begin
        if (!rst_i || r_state == IDLE) r_cnt <= '0;
        else if (!w_rsp)               r_cnt <= r_cnt + 1'b1;
    end

    assign w_tmo = (r_state != IDLE) && (r_cnt == CNT_W'(TIMEOUT)) && !w_rsp;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT > 0);
    assign w_tmo = 1'b0;
`endif

    always_comb begin
        s_addr_o  = '0;
        s_data_o  = '0;
        s_rd_o    = 1'b0;
        s_wr_o    = 1'b0;
        gnt_o     = 2'b00;
        m0_data_o = '0;
        m1_data_o = '0;
        w_ack     = 1'b0;
        w_err     = 1'b0;
        if (r_state != IDLE) begin
            s_addr_o  = w_addr;
            s_data_o  = w_data;
            gnt_o     = w_sel ? 2'b10 : 2'b01;
            m0_data_o = s_data_i;
            m1_data_o = s_data_i;
            if (w_req && !w_viol && !w_tmo) begin
                s_rd_o = w_rd;
                s_wr_o = w_wr;
            end
            // err dominates a simultaneous ack
            w_err = w_req && (w_viol || s_err_i || w_tmo);
            w_ack = w_req && !w_viol && s_ack_i && !s_err_i;
        end
        m0_ack_o = w_ack & ~w_sel;
        m0_err_o = w_err & ~w_sel;
        m1_ack_o = w_ack &  w_sel;
        m1_err_o = w_err &  w_sel;
    end

    always_comb begin
        w_next     = r_state;
        w_last_nxt = r_last;
        case (r_state)
            IDLE: begin
                if ((m0_rd_i | m0_wr_i) && (m1_rd_i | m1_wr_i)) w_next = r_last ? GNT0 : GNT1;
                else if (m0_rd_i | m0_wr_i)                     w_next = GNT0;
                else if (m1_rd_i | m1_wr_i)                     w_next = GNT1;
            end
            default: begin
                if (!w_req) begin
                    w_next = IDLE;
                end else if (w_viol || w_rsp || w_tmo) begin
                    w_next     = IDLE;
                    w_last_nxt = w_sel;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_last  <= w_last_nxt;
        end
    end
endmodule

// File: tb/tb_o8_bus_arbiter.sv
// Bench for o8_bus_arbiter: directed scenarios, then random masters/slave against a cycle model.
module tb_o8_bus_arbiter;
    localparam int AW = 16, DW = 8, TMO = 15;
`ifdef O8_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic rst_i;
    logic [AW-1:0] ma [2];
    logic [DW-1:0] md [2];
    logic mrd [2], mwr [2];
    logic [DW-1:0] s_data_i;
    logic s_ack_i, s_err_i;
    logic [DW-1:0] m0_data_o, m1_data_o, s_data_o;
    logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_rd_o, s_wr_o;
    logic [AW-1:0] s_addr_o;
    logic [1:0] gnt_o;

    o8_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_addr_i(ma[0]), .m0_data_i(md[0]), .m0_rd_i(mrd[0]), .m0_wr_i(mwr[0]),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(ma[1]), .m1_data_i(md[1]), .m1_rd_i(mrd[1]), .m1_wr_i(mwr[1]),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_data_i(s_data_i),
        .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
        .gnt_o(gnt_o)
    );

    int nerr = 0, nchk = 0;
    // owner: 0 = nobody, 1 = m0, 2 = m1; last: index of master served last
    int own, last, cnt, n_own, n_last, n_cnt;
    logic e_srd, e_swr;
    logic [1:0] e_gnt;
    logic e_ack [2], e_err [2];
    logic [AW-1:0] e_saddr;
    logic [DW-1:0] e_sdata, e_mdo;
    bit act [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(logic rd, logic wr, logic [1:0] g, logic a0, logic a1,
                                       logic r0, logic r1, logic [AW-1:0] ad, logic [DW-1:0] sd,
                                       logic [DW-1:0] d0, logic [DW-1:0] d1);
        return {16'h0, rd, wr, g, a0, a1, r0, r1, ad, sd, d0, d1};
    endfunction

    function automatic void model_out();
        int n;
        bit rq, vl, rsp, to;
        e_srd = 0; e_swr = 0; e_gnt = 0; e_saddr = 0; e_sdata = 0; e_mdo = 0;
        e_ack[0] = 0; e_ack[1] = 0; e_err[0] = 0; e_err[1] = 0;
        if (own != 0) begin
            n   = own - 1;
            rq  = mrd[n] | mwr[n];
            vl  = mrd[n] & mwr[n];
            rsp = s_ack_i | s_err_i;
            to  = TMO_EN && cnt == TMO && !rsp;
            e_gnt   = 2'(1 << n);
            e_saddr = ma[n];
            e_sdata = md[n];
            e_mdo   = s_data_i;
            if (rq && !vl && !to) begin
                e_srd = mrd[n];
                e_swr = mwr[n];
            end
            e_err[n] = rq && (vl || s_err_i || to);
            e_ack[n] = rq && !vl && s_ack_i && !s_err_i;
        end
    endfunction

    function automatic void model_next();
        bit r0, r1, rq, fin;
        int n;
        r0 = mrd[0] | mwr[0];
        r1 = mrd[1] | mwr[1];
        n_own = own; n_last = last; n_cnt = cnt;
        if (!rst_i) begin
            n_own = 0; n_last = 1; n_cnt = 0;
        end else if (own == 0) begin
            n_cnt = 0;
            if (r0 && r1) n_own = (last == 0) ? 2 : 1;
            else if (r0)  n_own = 1;
            else if (r1)  n_own = 2;
        end else begin
            n   = own - 1;
            rq  = mrd[n] | mwr[n];
            fin = (mrd[n] & mwr[n]) || s_ack_i || s_err_i || (TMO_EN && cnt == TMO);
            if (!rq)      n_own = 0;
            else if (fin) begin n_own = 0; n_last = n; end
            else          n_cnt = cnt + 1;
        end
    endfunction

    task automatic sample();
        @(negedge clk_i);
        model_out();
        chk("bus", pk(s_rd_o, s_wr_o, gnt_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o,
                      s_addr_o, s_data_o, m0_data_o, m1_data_o),
                   pk(e_srd, e_swr, e_gnt, e_ack[0], e_ack[1], e_err[0], e_err[1],
                      e_saddr, e_sdata, e_mdo, e_mdo));
        model_next();
    endtask

    task automatic adv();
        @(posedge clk_i);
        own = n_own; last = n_last; cnt = n_cnt;
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    initial begin
        logic [1:0] t2 [8];
        t2 = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
        own = 0; last = 1; cnt = 0;
        rst_i = 0; s_data_i = 0; s_ack_i = 0; s_err_i = 0;
        for (int i = 0; i < 2; i++) begin ma[i] = 0; md[i] = 0; mrd[i] = 0; mwr[i] = 0; act[i] = 0; end
        step();
        sample(); chk("rst_gnt", gnt_o, 0); chk("rst_strb", {s_rd_o, s_wr_o}, 0); adv();
        rst_i = 1;

        // single read from m0, acked in first granted cycle
        mrd[0] = 1; ma[0] = 16'h1234;
        sample(); chk("t1_idle_gnt", gnt_o, 0); adv();
        s_ack_i = 1; s_data_i = 8'h5A;
        sample();
        chk("t1_gnt", gnt_o, 2'b01);
        chk("t1_addr", s_addr_o, 16'h1234);
        chk("t1_ack", m0_ack_o, 1);
        chk("t1_data", m0_data_o, 8'h5A);
        chk("t1_m1ack", m1_ack_o, 0);
        adv();
        mrd[0] = 0; s_ack_i = 0;
        sample(); chk("t1_after", gnt_o, 0); adv();

        // both masters continuously requesting after reset: strict alternation
        rst_i = 0; step(); rst_i = 1;
        mrd[0] = 1; mrd[1] = 1; s_ack_i = 1;
        for (int i = 0; i < 8; i++) begin
            sample(); chk("t2_gnt", gnt_o, t2[i]); adv();
        end
        mrd[0] = 0; mrd[1] = 0; s_ack_i = 0;
        step();

        // m1 write, slave returns ack and err together
        mwr[1] = 1; ma[1] = 16'hE000; md[1] = 8'h1A;
        step();
        s_ack_i = 1; s_err_i = 1;
        sample();
        chk("t3_wr", s_wr_o, 1);
        chk("t3_data", s_data_o, 8'h1A);
        chk("t3_err", m1_err_o, 1);
        chk("t3_ack", m1_ack_o, 0);
        adv();
        mwr[1] = 0; s_ack_i = 0; s_err_i = 0;
        sample(); chk("t3_idle", gnt_o, 0); adv();

        // rd+wr together from m0, then a normal read
        mrd[0] = 1; mwr[0] = 1; ma[0] = 16'h0042;
        sample(); chk("t4_idle_strb", {s_rd_o, s_wr_o}, 0); adv();
        sample(); chk("t4_strb", {s_rd_o, s_wr_o}, 0); chk("t4_err", m0_err_o, 1); adv();
        mwr[0] = 0;
        sample(); chk("t4_bubble", {s_rd_o, gnt_o}, 0); adv();
        s_ack_i = 1;
        sample(); chk("t4_next_rd", s_rd_o, 1); chk("t4_next_ack", m0_ack_o, 1); adv();
        mrd[0] = 0; s_ack_i = 0;
        step();

        // reset while m1 holds the slave
        mrd[1] = 1; ma[1] = 16'hBEEF;
        step();
        rst_i = 0;
        sample(); chk("t5_rd", s_rd_o, 1); chk("t5_gnt", gnt_o, 2'b10); adv();
        rst_i = 1; mrd[0] = 1;
        sample(); chk("t5_drop", {s_rd_o, gnt_o}, 0); adv();
        s_ack_i = 1;
        sample(); chk("t5_tie", gnt_o, 2'b01); adv();
        mrd[0] = 0; mrd[1] = 0; s_ack_i = 0;
        step();

        // silent slave
        mrd[0] = 1; ma[0] = 16'h7777;
        step();
`ifdef O8_ARB_TIMEOUT_EN
        for (int i = 1; i <= 16; i++) begin
            sample();
            if (i < 16) chk("t6_wait_err", m0_err_o, 0);
            else begin chk("t6_err", m0_err_o, 1); chk("t6_strb", s_rd_o, 0); end
            adv();
        end
        mrd[0] = 0;
        sample(); chk("t6_idle", gnt_o, 0); adv();
`else
        for (int i = 0; i < 110; i++) begin
            sample(); chk("t6_hold", gnt_o, 2'b01); adv();
        end
        mrd[0] = 0;
        sample(); chk("t6_abort_strb", s_rd_o, 0); adv();
        sample(); chk("t6_idle", gnt_o, 0); adv();
`endif

        // random masters and slave
        for (int c = 0; c < 3000; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (act[n] && (e_ack[n] || e_err[n] || $urandom_range(0, 19) == 0)) begin
                    act[n] = 0; mrd[n] = 0; mwr[n] = 0;
                end else if (!act[n] && $urandom_range(0, 2) == 0) begin
                    int k;
                    act[n] = 1;
                    ma[n] = AW'($urandom);
                    md[n] = DW'($urandom);
                    k = $urandom_range(0, 9);
                    mrd[n] = (k < 5);
                    mwr[n] = (k == 0) || (k >= 5);
                end
            end
            rst_i = ($urandom_range(0, 299) != 0);
            s_data_i = DW'($urandom);
            s_ack_i = 0; s_err_i = 0;
            model_out();
            if ((e_srd || e_swr) && $urandom_range(0, 1) == 1) begin
                int k;
                k = $urandom_range(0, 5);
                s_ack_i = (k != 4);
                s_err_i = (k >= 4);
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/o8_bus_arbiter.md
Name: o8_bus_arbiter

Overview:
Two-master, one-slave arbiter for the o8 memory bus (addr/data/rd/wr/ack/err). Master 0 is the o8_cpu; master 1 is a second bus master such as a DMA or loader engine. The arbiter grants the single memory port to one master per transaction and routes strobes, address and write data to the slave. It returns ack, err and read data to the granted master only.

Parameters:
ADDR_W, 16, address width
DATA_W, 8, data width
TIMEOUT, 15, max wait cycles for ack/err in GRANT (used only with O8_ARB_TIMEOUT_EN)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  reset, synchronous, active-low
m0_addr_i  in  ADDR_W  master 0 address
m0_data_i  in  DATA_W  master 0 write data
m0_rd_i  in  1  master 0 read request
m0_wr_i  in  1  master 0 write request
m0_data_o  out  DATA_W  read data to master 0
m0_ack_o  out  1  master 0 transfer complete
m0_err_o  out  1  master 0 transfer error
m1_addr_i, m1_data_i, m1_rd_i, m1_wr_i, m1_data_o, m1_ack_o, m1_err_o  as above, master 1
s_addr_o  out  ADDR_W  slave address
s_data_o  out  DATA_W  slave write data
s_data_i  in  DATA_W  slave read data
s_rd_o  out  1  slave read strobe
s_wr_o  out  1  slave write strobe
s_ack_i  in  1  slave ack
s_err_i  in  1  slave error
gnt_o  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 0 when idle

Behaviour:
- Requests: mN_req = mN_rd_i | mN_wr_i. A master holds its request, address and data stable until it sees ack or err.
- States: IDLE, GNT0, GNT1. State and the round-robin pointer `last` are registered.
- Reset (rst_i = 0 at an edge): state goes to IDLE and `last` is set to 1, so m0 wins the first tie. In IDLE all outputs are 0: s_rd_o, s_wr_o, s_addr_o, s_data_o, gnt_o, and all mN_ack_o/mN_err_o. Reset mid-transaction drops slave strobes at that edge; nothing is forwarded afterwards.
- IDLE:
  - Only m0_req: go to GNT0.
  - Only m1_req: go to GNT1.
  - Both: grant the master not equal to `last`.
  - Neither: stay in IDLE.
  - No slave strobe is driven in IDLE, so arbitration costs exactly 1 cycle.
- GNTn:
  - s_addr_o, s_data_o, s_rd_o and s_wr_o combinationally follow master n. gnt_o = onehot(n).
  - mn_ack_o = s_ack_i and mn_err_o = s_err_i, combinationally.
  - The non-granted master sees ack = err = 0.
  - s_data_i is broadcast to both mN_data_o. Only the acked master may sample it.
- Completion: on a cycle with s_ack_i or s_err_i in GNTn, set `last` = n and go to IDLE at the next edge. There is always one idle bubble between transactions, including back-to-back requests from the same master.
- ack and err asserted together: err wins. The master sees err = 1 and ack = 0.
- Abort: master n drops its request while in GNTn. Strobes drop combinationally, state returns to IDLE, `last` is unchanged.
- Protocol violation: rd and wr both high from master n in GNTn. No slave strobe is driven. mn_err_o = 1 for that cycle, then go to IDLE and set `last` = n.
- Requests from the non-granted master are held pending. No starvation: with continuous requests from both masters, grants strictly alternate.
- Latency: request seen in IDLE at cycle k. Slave strobe is asserted in cycle k+1. Master ack arrives in the same cycle as s_ack_i, no added delay.

Optional Feature:
O8_ARB_TIMEOUT_EN
- Defined: a 4+ bit counter clears on entry to GNTn and increments each GNTn cycle without ack/err. If the counter equals TIMEOUT in a GNTn cycle with no slave response, the arbiter:
  - forces s_rd_o = s_wr_o = 0,
  - asserts mn_err_o = 1 for that cycle,
  - sets `last` = n and goes to IDLE.
- Undefined: no counter; the arbiter waits in GNTn indefinitely.

Test Plan:
1. Reset, then m0_rd_i = 1, addr 0x1234, slave acks in 1st granted cycle with data 0x5A -> gnt_o = 01 one cycle after request; s_addr_o = 0x1234; m0_ack_o = 1 and m0_data_o = 0x5A in the same cycle; m1_ack_o = 0.
2. m0 and m1 request simultaneously after reset, each re-requesting immediately, 4 transactions -> grant order m0, m1, m0, m1 with one IDLE cycle between each.
3. m1_wr_i = 1, addr 0xE000, data 0x1A; slave asserts s_ack_i and s_err_i together -> s_wr_o = 1, s_data_o = 0x1A, m1_err_o = 1, m1_ack_o = 0; IDLE next cycle.
4. m0 asserts rd and wr together -> s_rd_o = s_wr_o = 0 throughout, m0_err_o = 1 in the first granted cycle; the next request is granted normally.
5. rst_i driven low while in GNT1 with s_rd_o = 1 -> s_rd_o = 0 and gnt_o = 00 after that edge; the first post-reset tie goes to m0.
6. With O8_ARB_TIMEOUT_EN and TIMEOUT = 15, slave never acks -> m0_err_o pulses on the 16th granted cycle and strobes drop; without the macro, gnt_o stays 01 for 100+ cycles.
